// File: rtl/beam_sum.sv
// Delay-and-sum beam combiner: snapshots 16 delayed PCM channels on a strobe,
// accumulates them one per cycle, then scales, saturates and emits one sample.
module beam_sum #(
  parameter int IN_W  = 19,
  parameter int SHIFT = 4,
  parameter int OUT_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [15:0]             ch_mask,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_0,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_1,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_2,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_3,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_4,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_5,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_6,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_7,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_8,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_9,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_10,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_11,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_12,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_13,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_14,
  input  logic signed [IN_W-1:0]  delayed_pcm_data_15,
  output logic signed [OUT_W-1:0] sum_out,
  output logic                    out_valid,
  output logic                    sat,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int ACC_W = IN_W + 4;

  localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(-(2**(OUT_W-1)));
  localparam logic signed [OUT_W-1:0] SUM_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SUM_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [IN_W-1:0]  din  [16];
  logic signed [IN_W-1:0]  snap [16];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_add;
  logic [3:0]              idx;
  logic                    sat_r;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] v);
    return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  // Returns {clamped, value}: clamp the scaled sum to the output range.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > LIM_MAX)      return {1'b1, SUM_MAX};
    else if (v < LIM_MIN) return {1'b1, SUM_MIN};
    else                  return {1'b0, v[OUT_W-1:0]};
  endfunction

  assign din[0]  = delayed_pcm_data_0;
  assign din[1]  = delayed_pcm_data_1;
  assign din[2]  = delayed_pcm_data_2;
  assign din[3]  = delayed_pcm_data_3;
  assign din[4]  = delayed_pcm_data_4;
  assign din[5]  = delayed_pcm_data_5;
  assign din[6]  = delayed_pcm_data_6;
  assign din[7]  = delayed_pcm_data_7;
  assign din[8]  = delayed_pcm_data_8;
  assign din[9]  = delayed_pcm_data_9;
  assign din[10] = delayed_pcm_data_10;
  assign din[11] = delayed_pcm_data_11;
  assign din[12] = delayed_pcm_data_12;
  assign din[13] = delayed_pcm_data_13;
  assign din[14] = delayed_pcm_data_14;
  assign din[15] = delayed_pcm_data_15;

  assign acc_add = acc + sext(snap[idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (idx == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sat = sat_r & out_valid;

  // Snapshot stage, then one channel added per ACCUM cycle; the last add
  // feeds the scaler/saturator directly so the result is ready in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) snap[i] <= '0;
      acc     <= '0;
      idx     <= '0;
      sum_out <= '0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            for (int i = 0; i < 16; i++) snap[i] <= ch_mask[i] ? din[i] : '0;
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc_add;
          idx <= idx + 4'd1;
          if (idx == 4'd15) {sat_r, sum_out} <= saturate(acc_add >>> SHIFT);
        end
        default: ;
      endcase
    end
  end

  // A strobe while busy is dropped but flagged; a same-cycle clear loses.
  always_ff @(posedge clk) begin
    if (rst)                              overrun <= 1'b0;
    else if (sample_valid && state != IDLE) overrun <= 1'b1;
    else if (overrun_clr)                 overrun <= 1'b0;
  end

endmodule

// File: tb/tb_beam_sum.sv
// Randomized scoreboard bench for beam_sum, two builds (SHIFT=4 and SHIFT=0)
// driven with identical stimulus and checked against an arithmetic model.
module tb_beam_sum;

  typedef int vec_t [16];
  typedef struct {
    int due;
    int val;
    bit sat;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    sample_valid = 1'b0;
  logic                    overrun_clr = 1'b0;
  logic [15:0]             mask = '0;
  logic signed [18:0]      din [16];
  logic signed [18:0]      so4, so0;
  logic                    vld4, vld0, sat4, sat0, busy4, busy0, ovr4, ovr0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_t = -100;
  int   abort_at = -100;
  bit   exp_ov = 0;
  bit   rst_d = 0;
  int   exp_last [2] = '{0, 0};
  exp_t q [2][$];
  vec_t vv;

  beam_sum #(.IN_W(19), .SHIFT(4), .OUT_W(19)) u_s4 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .ch_mask(mask),
    .delayed_pcm_data_0(din[0]),   .delayed_pcm_data_1(din[1]),
    .delayed_pcm_data_2(din[2]),   .delayed_pcm_data_3(din[3]),
    .delayed_pcm_data_4(din[4]),   .delayed_pcm_data_5(din[5]),
    .delayed_pcm_data_6(din[6]),   .delayed_pcm_data_7(din[7]),
    .delayed_pcm_data_8(din[8]),   .delayed_pcm_data_9(din[9]),
    .delayed_pcm_data_10(din[10]), .delayed_pcm_data_11(din[11]),
    .delayed_pcm_data_12(din[12]), .delayed_pcm_data_13(din[13]),
    .delayed_pcm_data_14(din[14]), .delayed_pcm_data_15(din[15]),
    .sum_out(so4), .out_valid(vld4), .sat(sat4), .busy(busy4),
    .overrun(ovr4), .overrun_clr(overrun_clr)
  );

  beam_sum #(.IN_W(19), .SHIFT(0), .OUT_W(19)) u_s0 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .ch_mask(mask),
    .delayed_pcm_data_0(din[0]),   .delayed_pcm_data_1(din[1]),
    .delayed_pcm_data_2(din[2]),   .delayed_pcm_data_3(din[3]),
    .delayed_pcm_data_4(din[4]),   .delayed_pcm_data_5(din[5]),
    .delayed_pcm_data_6(din[6]),   .delayed_pcm_data_7(din[7]),
    .delayed_pcm_data_8(din[8]),   .delayed_pcm_data_9(din[9]),
    .delayed_pcm_data_10(din[10]), .delayed_pcm_data_11(din[11]),
    .delayed_pcm_data_12(din[12]), .delayed_pcm_data_13(din[13]),
    .delayed_pcm_data_14(din[14]), .delayed_pcm_data_15(din[15]),
    .sum_out(so0), .out_valid(vld0), .sat(sat0), .busy(busy0),
    .overrun(ovr0), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_d <= rst;

  // A sample accepted in cycle acc_t keeps the block busy for the next 17
  // cycles unless a reset lands in between.
  function automatic bit exp_busy(input int k);
    return (k > acc_t) && (k <= acc_t + 17) && !(abort_at >= acc_t && abort_at < k);
  endfunction

  always @(posedge clk) begin
    if (rst)                                 exp_ov <= 1'b0;
    else if (sample_valid && exp_busy(cyc))  exp_ov <= 1'b1;
    else if (overrun_clr)                    exp_ov <= 1'b0;
  end

  // Masked sum, floor division by 2^shift, clamp to the 19-bit signed range.
  function automatic exp_t model(input logic [15:0] m, input int sh, input int due);
    exp_t   e;
    longint sum = 0;
    longint d   = longint'(1) << sh;
    longint s;
    for (int i = 0; i < 16; i++) if (m[i]) sum += vv[i];
    s = (sum >= 0) ? sum / d : -((-sum + d - 1) / d);
    e.due = due;
    if (s > 262143)       begin e.val = 262143;  e.sat = 1; end
    else if (s < -262144) begin e.val = -262144; e.sat = 1; end
    else                  begin e.val = int'(s); e.sat = 0; end
    return e;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_inst(input int id, input logic signed [18:0] so, input logic vld,
                            input logic st, input logic bsy, input logic ovr);
    exp_t e;
    bit   ev;
    if (rst_d) exp_last[id] = 0;
    while (q[id].size() > 0 && q[id][0].due < cyc) begin
      chk(1'b0, "missed_out_valid", cyc, q[id][0].due);
      void'(q[id].pop_front());
    end
    ev = (q[id].size() > 0) && (q[id][0].due == cyc);
    chk(vld == ev, "out_valid", int'(vld), int'(ev));
    chk(bsy == exp_busy(cyc), "busy", int'(bsy), int'(exp_busy(cyc)));
    chk(ovr == exp_ov, "overrun", int'(ovr), int'(exp_ov));
    if (ev) begin
      e = q[id].pop_front();
      chk(so == e.val, id == 0 ? "sum_out_s4" : "sum_out_s0", int'(so), e.val);
      chk(st == e.sat, id == 0 ? "sat_s4" : "sat_s0", int'(st), int'(e.sat));
      exp_last[id] = e.val;
    end else begin
      chk(so == exp_last[id], "sum_out_hold", int'(so), exp_last[id]);
      chk(st == 1'b0, "sat_idle", int'(st), 0);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_inst(0, so4, vld4, sat4, busy4, ovr4);
      check_inst(1, so0, vld0, sat0, busy0, ovr0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd19();
    int r = int'($urandom_range(0, 524287));
    return (r >= 262144) ? r - 524288 : r;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 16; i++) din[i] = 19'(rnd19());
    mask = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      scramble();
      next_cycle();
    end
  endtask

  task automatic fill(input int base, input int step);
    for (int i = 0; i < 16; i++) vv[i] = base + step * i;
  endtask

  task automatic strobe(input logic [15:0] m, input bit clr);
    for (int i = 0; i < 16; i++) din[i] = 19'(vv[i]);
    mask         = m;
    sample_valid = 1'b1;
    overrun_clr  = clr;
    if (!rst && !exp_busy(cyc)) begin
      q[0].push_back(model(m, 4, cyc + 17));
      q[1].push_back(model(m, 0, cyc + 17));
      acc_t = cyc;
    end
    next_cycle();
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
    scramble();
  endtask

  task automatic clr_pulse();
    overrun_clr = 1'b1;
    next_cycle();
    overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    abort_at = cyc;
    for (int id = 0; id < 2; id++)
      while (q[id].size() > 0 && q[id][$].due > cyc) void'(q[id].pop_back());
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) din[i] = '0;
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    idle(2);

    fill(1, 0);       strobe(16'hFFFF, 0); idle(20);
    fill(262143, 0);  strobe(16'hFFFF, 0); idle(20);
    fill(-262144, 0); strobe(16'hFFFF, 0); idle(20);
    fill(-5, 0);      strobe(16'hFFFF, 0); idle(20);
    fill(-1, -1);     strobe(16'hFFFF, 0); idle(20);
    fill(1, 1);       strobe(16'h00FF, 0); idle(20);
    fill(1, 1);       strobe(16'h0000, 0); idle(20);

    // Overrun: strobe at T+5 dropped, strobe at T+18 accepted, sticky flag.
    fill(7, 3);       strobe(16'hFFFF, 0);
    idle(4);
    fill(100, 0);     strobe(16'hFFFF, 0);
    idle(12);
    fill(-9, 2);      strobe(16'hF0F0, 0);
    idle(25);
    clr_pulse();
    idle(3);

    // Set and clear in the same cycle: set must win.
    fill(50, -7);     strobe(16'hFFFF, 0);
    idle(2);
    fill(100, 0);     strobe(16'hFFFF, 1);
    idle(18);
    clr_pulse();
    idle(2);

    // Reset mid-accumulation aborts the sample.
    fill(1000, 0);    strobe(16'hFFFF, 0);
    idle(7);
    do_reset();
    idle(15);
    fill(-3, 1);      strobe(16'hFFFF, 0); idle(20);

    repeat (40) begin
      int mode = int'($urandom_range(0, 3));
      int gap  = int'($urandom_range(17, 22));
      for (int i = 0; i < 16; i++)
        vv[i] = (mode == 0) ? 262143 : (mode == 1) ? -262144 : rnd19();
      strobe(16'($urandom), 0);
      if ($urandom_range(0, 2) == 0) begin
        int p = int'($urandom_range(1, 15));
        idle(p);
        for (int i = 0; i < 16; i++) vv[i] = rnd19();
        strobe(16'($urandom), 1'($urandom_range(0, 1)));
        idle(gap - p - 1);
      end else begin
        idle(gap);
      end
      if ($urandom_range(0, 3) == 0) clr_pulse();
    end

    idle(30);
    chk(q[0].size() == 0, "pending_s4", q[0].size(), 0);
    chk(q[1].size() == 0, "pending_s0", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
